seq_divider: RTL

Multicycle unsigned integer divider built around a subtract-and-restore datapath: one trial subtraction per clock, implemented as an add of the complemented divisor with carry-in 1, reusing the team's 4-bit carry-lookahead adder slices. It is the inverse-direction companion of the adder. It sits beside the ALU in the execute stage. The pipeline drives a start/done handshake and stalls on `busy` while the division iterates.

---
 rtl/seq_divider.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Multicycle restoring unsigned divider: one trial subtraction per clock through
// a chain of 4-bit carry-lookahead slices, with a start/busy/done handshake.
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int NS = WIDTH / 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH:0]   p_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             busy_r;
    logic             done_r;
    logic             dbz_r;

    logic [WIDTH:0]   p_shift_s;
    logic [WIDTH:0]   diff_s;
    logic             no_borrow_s;
    logic [WIDTH:0]   next_p_s;
    logic [WIDTH-1:0] next_q_s;

    // 4-bit carry-lookahead slice, returns {carry_out, sum}.
    function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic cin);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        return {c[4], p ^ c[3:0]};
    endfunction

    // Trial subtraction P_shifted - divisor as P_shifted + ~{0,divisor} + 1.
    always_comb begin
        logic       c_v;
        logic [4:0] sl_v;
        p_shift_s = {p_r[WIDTH-1:0], q_r[WIDTH-1]};
        diff_s    = {(WIDTH+1){1'b0}};
        c_v       = 1'b1;
        sl_v      = 5'd0;
        for (int i = 0; i < NS; i++) begin
            sl_v              = cla4(p_shift_s[4*i +: 4], ~dvs_r[4*i +: 4], c_v);
            diff_s[4*i +: 4]  = sl_v[3:0];
            c_v               = sl_v[4];
        end
        // Top bit adds the complemented zero extension (a constant 1).
        diff_s[WIDTH] = ~(p_shift_s[WIDTH] ^ c_v);
        no_borrow_s   = p_shift_s[WIDTH] | c_v;
        if (no_borrow_s) begin
            next_p_s = diff_s;
        end else begin
            next_p_s = p_shift_s;
        end
        next_q_s = {q_r[WIDTH-2:0], no_borrow_s};
    end

    // Control FSM, iteration datapath and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            p_r         <= {(WIDTH+1){1'b0}};
            q_r         <= {WIDTH{1'b0}};
            dvs_r       <= {WIDTH{1'b0}};
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            dbz_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        if (divisor == {WIDTH{1'b0}}) begin
                            state_r     <= DONE;
                            busy_r      <= 1'b0;
                            done_r      <= 1'b1;
                            quotient_r  <= {WIDTH{1'b1}};
                            remainder_r <= dividend;
                            dbz_r       <= 1'b1;
                        end else begin
                            state_r <= RUN;
                            busy_r  <= 1'b1;
                            done_r  <= 1'b0;
                            dvs_r   <= divisor;
                            p_r     <= {(WIDTH+1){1'b0}};
                            q_r     <= dividend;
                            cnt_r   <= {CW{1'b0}};
                            dbz_r   <= 1'b0;
                        end
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                RUN: begin
                    p_r   <= next_p_s;
                    q_r   <= next_q_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == CW'(WIDTH - 1)) begin
                        state_r     <= DONE;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        quotient_r  <= next_q_s;
                        remainder_r <= next_p_s[WIDTH-1:0];
                    end else begin
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;

endmodule
